// File: rtl/io_responder.sv
// Memory-mapped board I/O for the single-cycle MIPS core: switches, buttons,
// LEDs, an eight-digit seven-segment scanner and a cycle timer with compare.
module io_responder #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IORead,
  input  logic        IOWrite,
  input  logic [9:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic [15:0] switch_i,
  input  logic [4:0]  button_i,
  output logic [15:0] led_o,
  output logic [7:0]  seg_an_o,
  output logic [7:0]  seg_o,
  output logic        timer_match_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  localparam logic [9:0] A_SW     = 10'h000;
  localparam logic [9:0] A_BTN    = 10'h010;
  localparam logic [9:0] A_LED    = 10'h060;
  localparam logic [9:0] A_SEG    = 10'h070;
  localparam logic [9:0] A_TIMER  = 10'h080;
  localparam logic [9:0] A_CMP    = 10'h084;
  localparam logic [9:0] A_STATUS = 10'h088;

  logic [15:0]   sw_meta_q, sw_sync_q;
  logic [4:0]    btn_meta_q, btn_sync_q;
  logic [15:0]   led_q, led_d;
  logic [31:0]   seg_q, seg_d;
  logic [31:0]   timer_q, timer_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          match_q, match_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    nibble;

  always_comb begin
    led_d   = led_q;
    seg_d   = seg_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    timer_d = timer_q + 32'd1;
    if (IOWrite) begin
      case (io_addr)
        A_LED:    led_d = io_wdata[15:0];
        A_SEG:    seg_d = io_wdata;
        A_TIMER:  timer_d = 32'd0;
        A_CMP:    cmp_d = io_wdata;
        A_STATUS: if (io_wdata[0]) match_d = 1'b0;
        default:  ;
      endcase
    end
    // a new compare hit outranks a software clear in the same cycle
    if (timer_q == cmp_q) match_d = 1'b1;
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      led_q      <= '0;
      seg_q      <= '0;
      timer_q    <= '0;
      cmp_q      <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
    end else begin
      sw_meta_q  <= switch_i;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= button_i;
      btn_sync_q <= btn_meta_q;
      led_q      <= led_d;
      seg_q      <= seg_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    io_rdata = 32'd0;
    if (IORead) begin
      case (io_addr)
        A_SW:     io_rdata = {16'd0, sw_sync_q};
        A_BTN:    io_rdata = {27'd0, btn_sync_q};
        A_LED:    io_rdata = {16'd0, led_q};
        A_SEG:    io_rdata = seg_q;
        A_TIMER:  io_rdata = timer_q;
        A_CMP:    io_rdata = cmp_q;
        A_STATUS: io_rdata = {31'd0, match_q};
        default:  io_rdata = 32'd0;
      endcase
    end
  end

  // glyphs are {dp,g,f,e,d,c,b,a}, active-low, dp held off
  always_comb begin
    nibble = seg_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0:    seg_o = 8'hC0;
      4'h1:    seg_o = 8'hF9;
      4'h2:    seg_o = 8'hA4;
      4'h3:    seg_o = 8'hB0;
      4'h4:    seg_o = 8'h99;
      4'h5:    seg_o = 8'h92;
      4'h6:    seg_o = 8'h82;
      4'h7:    seg_o = 8'hF8;
      4'h8:    seg_o = 8'h80;
      4'h9:    seg_o = 8'h90;
      4'hA:    seg_o = 8'h88;
      4'hB:    seg_o = 8'h83;
      4'hC:    seg_o = 8'hC6;
      4'hD:    seg_o = 8'hA1;
      4'hE:    seg_o = 8'h86;
      default: seg_o = 8'h8E;
    endcase
  end

  assign seg_an_o      = ~(8'b0000_0001 << idx_q);
  assign led_o         = led_q;
  assign timer_match_o = match_q;

endmodule
